demux_1to4_stream: RTL and testbench
====================================

# demux_1to4_stream

Registered 1-to-4 stream demultiplexer: the distributing counterpart to the team's 4:1 mux tree. A single valid/ready input stream carries a 2-bit destination select with each word. The word is routed into a one-entry holding register on the selected output channel, and each channel drains independently through its own valid/ready handshake. It sits where one producer fans out to four consumers, for example before four per-lane processing units.

## Interface
Parameters:
- DATA_W, 8, width of each data word
- CNT_W, 16, width of each per-channel transfer counter (only used when DEMUX_STATS_EN is defined)

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk  input  1  clock; all state updates on the rising edge
  - rst_n  input  1  synchronous active-low reset
- Input stream:
  - in_data  input  DATA_W  input word
  - in_sel  input  2  destination channel (0..3), qualified by in_valid
  - in_valid  input  1  input word valid
  - in_ready  output  1  block can accept the word on this cycle
- Output channels:
  - out_data  output  4*DATA_W  packed lanes; lane k = out_data[k*DATA_W +: DATA_W]
  - out_valid  output  4  per-channel valid
  - out_ready  input  4  per-channel consumer ready
- Statistics (only when DEMUX_STATS_EN is defined):
  - xfer_cnt  output  4*CNT_W  packed per-channel completed-transfer counters; lane k = xfer_cnt[k*CNT_W +: CNT_W]

## Operation
- State per channel k:
  - slot_v[k], 1 bit
  - slot_d[k], DATA_W bits
  - out_valid[k] = slot_v[k]
  - out_data lane k = slot_d[k]
- in_ready = !slot_v[in_sel] || out_ready[in_sel]. This is combinational from in_sel and out_ready: a full slot accepts a new word only when it drains on the same cycle.
- Accept (in_valid && in_ready), with s = in_sel:
  - slot_d[s] <= in_data
  - slot_v[s] <= 1
- Drain on channel k (out_valid[k] && out_ready[k]):
  - slot_v[k] <= 0, unless an accept targets k on the same cycle, in which case slot_v[k] stays 1 and slot_d[k] takes the new word.
- Channels not targeted and not draining hold slot_v and slot_d unchanged.
- Data of an empty slot is don't-care to consumers. It holds its last value and is not zeroed on drain.
- Words for the same channel leave in acceptance order. No ordering is defined between channels.
- in_sel and in_data are ignored when in_valid = 0. in_ready is still driven from in_sel.
- A blocked channel (slot full, out_ready low) stalls only words addressed to it. The next word to a different channel is accepted as soon as it is presented.
- Reset (rst_n = 0 at a rising edge):
  - slot_v = 4'b0000, so out_valid = 0
  - all slot_d = 0, so out_data = 0
  - all xfer_cnt = 0
  - A word in flight at reset is dropped. in_ready is therefore 1 from the first cycle after reset.

## Timing
- Latency is 1 cycle: a word accepted at edge N shows on out_valid[in_sel] and its lane after edge N.
- Throughput is 1 word per cycle per channel while the consumer holds out_ready high, including back-to-back words to the same channel.
- in_ready has a combinational path from out_ready and in_sel. There is no combinational path from in_valid to out_valid.
- out_valid, once asserted, stays asserted and the lane data stays stable until the drain handshake.

## Configuration
- Macro: DEMUX_STATS_EN.
- When defined:
  - xfer_cnt exists.
  - Counter k increments by 1 on each drain handshake on channel k.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - It is cleared only by reset.
- When undefined:
  - The xfer_cnt port and all counter logic are absent.
  - Datapath behaviour is identical in both builds.

## Test plan
- Reset with rst_n=0 held for 2 cycles, then released:
  - out_valid=4'b0000, out_data=0, in_ready=1.
  - With stats built in, all xfer_cnt=0.
- Single routing: out_ready=4'b1111, send 0xA5 to sel 2 → next cycle out_valid=4'b0100, lane 2=0xA5. It clears the following cycle.
- Backpressure:
  - Setup: out_ready[1]=0, send 0x11 to sel 1.
  - Then present 0x22 to sel 1 → in_ready=0 and lane 1 stays 0x11.
  - Then present 0x33 to sel 3 → accepted at once.
  - Raise out_ready[1] → 0x22 is accepted on the drain cycle (simultaneous drain+fill) and out_valid[1] stays 1.
- Streaming: send 8 back-to-back words 0x00..0x07 to sel 0 with out_ready[0]=1 → in_ready stays 1 throughout and lane 0 shows 0x00..0x07 in order, one per cycle.
- Reset mid-operation:
  - Setup: fill all four slots with out_ready=0.
  - Assert rst_n=0 for one cycle → out_valid=0, out_data=0, in_ready=1.
  - The prior words never appear on the outputs.
- DEMUX_STATS_EN: build with CNT_W=4 and drain 20 words on channel 3 → xfer_cnt lane 3 = 15 (saturated), other lanes = 0.

Source files
------------

// File: rtl/demux_1to4_stream.sv
// 1-to-4 stream demux: one-entry holding slot per channel, 1-cycle latency, in_ready falls only when the
// selected slot is full and not draining this cycle. Per-channel saturating drain counters exist with DEMUX_STATS_EN.
module demux_1to4_stream #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [1:0]          in_sel,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [4*DATA_W-1:0] out_data,
   output logic [3:0]          out_valid,
   input  logic [3:0]          out_ready
`ifdef DEMUX_STATS_EN
   ,
   output logic [4*CNT_W-1:0]  xfer_cnt
`endif
);

   logic [3:0]        slot_v_q, slot_v_d;
   logic [DATA_W-1:0] slot_d_q [4];
   logic [DATA_W-1:0] slot_d_d [4];
   logic [3:0]        drain;
   logic              accept;

   always_comb begin
      in_ready = !slot_v_q[in_sel] || out_ready[in_sel];
      accept   = in_valid && in_ready;
      drain    = slot_v_q & out_ready;

      // A drain and an accept on the same channel leave the slot full with the new word.
      slot_v_d = slot_v_q & ~drain;
      for (int k = 0; k < 4; k++) begin
         slot_d_d[k] = slot_d_q[k];
      end
      if (accept) begin
         slot_v_d[in_sel] = 1'b1;
         slot_d_d[in_sel] = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_v_q <= 4'b0000;
         for (int k = 0; k < 4; k++) begin
            slot_d_q[k] <= '0;
         end
      end else begin
         slot_v_q <= slot_v_d;
         for (int k = 0; k < 4; k++) begin
            slot_d_q[k] <= slot_d_d[k];
         end
      end
   end

   always_comb begin
      out_valid = slot_v_q;
      out_data  = '0;
      for (int k = 0; k < 4; k++) begin
         out_data[k*DATA_W +: DATA_W] = slot_d_q[k];
      end
   end

`ifdef DEMUX_STATS_EN
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];

   always_comb begin
      xfer_cnt = '0;
      for (int k = 0; k < 4; k++) begin
         cnt_d[k] = cnt_q[k];
         if (drain[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
         end
         xfer_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end
`endif

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Scoreboard bench for demux_1to4_stream: per-channel expected-word queues filled by the driver, drained by a monitor.
module tb_demux_1to4_stream;

   localparam int DW = 8;
`ifdef DEMUX_STATS_EN
   localparam int CW = 4;
`else
   localparam int CW = 16;
`endif
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [1:0]    in_sel = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [4*DW-1:0] out_data;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready = 4'b0000;
`ifdef DEMUX_STATS_EN
   logic [4*CW-1:0] xfer_cnt;
`endif

   demux_1to4_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef DEMUX_STATS_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef logic [DW-1:0] word_q_t [$];
   word_q_t exp_q [4];
   int      cnt_model [4];
   int      n_checks = 0;
   int      n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] lane(input int k);
      return out_data[k*DW +: DW];
   endfunction

   // Monitor: outputs are stable mid-cycle; compare them with the model, then retire the words that drain.
   initial begin : monitor
      logic exp_v;
      logic exp_rdy;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            exp_rdy = (exp_q[in_sel].size() == 0) || out_ready[in_sel];
            chk("in_ready", in_ready, exp_rdy);
            for (int k = 0; k < 4; k++) begin
               exp_v = exp_q[k].size() != 0;
               chk($sformatf("out_valid[%0d]", k), out_valid[k], exp_v);
               if (exp_v) chk($sformatf("lane%0d_data", k), lane(k), exp_q[k][0]);
`ifdef DEMUX_STATS_EN
               chk($sformatf("xfer_cnt[%0d]", k), xfer_cnt[k*CW +: CW], cnt_model[k]);
`endif
            end
            for (int k = 0; k < 4; k++) begin
               if (exp_q[k].size() != 0 && out_ready[k]) begin
                  void'(exp_q[k].pop_front());
                  if (cnt_model[k] < CMAX) cnt_model[k]++;
               end
            end
         end
      end
   end

   // One cycle of input drive, starting at/after a falling edge; records the word if the DUT takes it.
   task automatic drive_cycle(input logic v, input logic [1:0] s, input logic [DW-1:0] d, output logic acc);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      #3;
      acc = v && in_ready;
      if (acc) exp_q[s].push_back(d);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [1:0] s, input logic [DW-1:0] d);
      logic acc;
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) drive_cycle(1'b1, s, d, acc);
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: word %0h to sel %0d not accepted in 50 cycles", d, s);
      end
   endtask

   task automatic do_reset(input int cycles);
      in_valid = 1'b0;
      rst_n = 1'b0;
      repeat (cycles) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         exp_q[k].delete();
         cnt_model[k] = 0;
      end
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 4'b0000);
      chk("rst_out_data", out_data, '0);
      chk("rst_in_ready", in_ready, 1'b1);
`ifdef DEMUX_STATS_EN
      chk("rst_xfer_cnt", xfer_cnt, '0);
`endif
      @(negedge clk);
   endtask

   initial begin : main
      logic acc;
      @(negedge clk);
      do_reset(2);

      // Single routing
      out_ready = 4'b1111;
      send(2'd2, 8'hA5);
      #1;
      chk("route_valid", out_valid, 4'b0100);
      chk("route_lane2", lane(2), 8'hA5);
      drive_cycle(1'b0, 2'd0, 8'h00, acc);
      #1;
      chk("route_clear", out_valid, 4'b0000);
      @(negedge clk);

      // Backpressure on channel 1 does not block channel 3; drain+fill keeps out_valid[1] high
      out_ready = 4'b1101;
      send(2'd1, 8'h11);
      drive_cycle(1'b1, 2'd1, 8'h22, acc);
      chk("bp_blocked", acc, 1'b0);
      chk("bp_lane1_hold", lane(1), 8'h11);
      drive_cycle(1'b1, 2'd3, 8'h33, acc);
      chk("bp_other_chan", acc, 1'b1);
      out_ready = 4'b1111;
      drive_cycle(1'b1, 2'd1, 8'h22, acc);
      chk("bp_drain_fill", acc, 1'b1);
      #1;
      chk("bp_valid1_held", out_valid[1], 1'b1);
      chk("bp_lane1_new", lane(1), 8'h22);
      @(negedge clk);
      drive_cycle(1'b0, 2'd0, 8'h00, acc);

      // Back-to-back streaming to channel 0
      out_ready = 4'b0001;
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, 2'd0, 8'(i), acc);
         chk("stream_ready", acc, 1'b1);
      end
      drive_cycle(1'b0, 2'd0, 8'h00, acc);

      // Reset with every slot full: the held words must vanish
      out_ready = 4'b0000;
      for (int k = 0; k < 4; k++) send(2'(k), 8'hC0 + 8'(k));
      do_reset(1);
      repeat (2) drive_cycle(1'b0, 2'd0, 8'h00, acc);

      // Random traffic with random consumer backpressure
      for (int i = 0; i < 800; i++) begin
         for (int k = 0; k < 4; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
         drive_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), acc);
      end
      out_ready = 4'b1111;
      repeat (2) drive_cycle(1'b0, 2'd0, 8'h00, acc);

`ifdef DEMUX_STATS_EN
      // Counter saturation on channel 3 only
      do_reset(1);
      out_ready = 4'b1111;
      for (int i = 0; i < 20; i++) send(2'd3, 8'(i));
      drive_cycle(1'b0, 2'd0, 8'h00, acc);
      #1;
      chk("sat_cnt3", xfer_cnt[3*CW +: CW], 15);
      chk("sat_cnt_others", xfer_cnt[3*CW-1:0], 0);
      @(negedge clk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
